// File: rtl/dm_pkg.sv
// Shared debug-module definitions: DMI opcodes, system-bus register addresses
// and the sbcs register layout.
package dm_pkg;

  typedef enum logic [1:0] {
    DMI_NOP   = 2'd0,
    DMI_READ  = 2'd1,
    DMI_WRITE = 2'd2
  } dmi_op_e;

  localparam logic [6:0] ADDR_SBCS       = 7'h38;
  localparam logic [6:0] ADDR_SBADDRESS0 = 7'h39;
  localparam logic [6:0] ADDR_SBADDRESS1 = 7'h3A;
  localparam logic [6:0] ADDR_SBDATA0    = 7'h3C;
  localparam logic [6:0] ADDR_SBDATA1    = 7'h3D;

  typedef struct packed {
    logic [2:0] sbversion;
    logic [5:0] zero0;
    logic       sbbusyerror;
    logic       sbbusy;
    logic       sbreadonaddr;
    logic [2:0] sbaccess;
    logic       sbautoincrement;
    logic       sbreadondata;
    logic [2:0] sberror;
    logic [6:0] sbasize;
    logic [4:0] sbaccess_caps;
  } sbcs_t;

endpackage

// File: rtl/sba_csr.sv
// System-bus-access CSR block: decodes DMI requests to sbcs/sbaddress/sbdata
// and drives the configuration and strobes consumed by the SBA master.
module sba_csr
  import dm_pkg::*;
#(
  parameter int SBASIZE = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        dmactive_i,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  input  logic [6:0]  dmi_addr_i,
  input  logic [1:0]  dmi_op_i,
  input  logic [31:0] dmi_data_i,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic [31:0] dmi_resp_data_o,
  output logic [63:0] sbaddress_o,
  output logic        sbaddress_write_valid_o,
  output logic        sbreadonaddr_o,
  output logic        sbautoincrement_o,
  output logic [2:0]  sbaccess_o,
  output logic        sbreadondata_o,
  output logic [63:0] sbdata_o,
  output logic        sbdata_read_valid_o,
  output logic        sbdata_write_valid_o,
  input  logic [63:0] sbaddress_next_i,
  input  logic [63:0] sbdata_i,
  input  logic        sbdata_valid_i,
  input  logic        sbbusy_i,
  input  logic        sberror_valid_i,
  input  logic [2:0]  sberror_i
);

  logic [63:0] r_sbaddress;
  logic [63:0] r_sbdata;
  logic        r_sbbusyerror;
  logic        r_sbreadonaddr;
  logic [2:0]  r_sbaccess;
  logic        r_sbautoincrement;
  logic        r_sbreadondata;
  logic [2:0]  r_sberror;
  logic        r_read_pending;
  logic        r_resp_valid;
  logic [31:0] r_resp_data;
  logic        r_addr_wv;
  logic        r_data_wv;
  logic        r_data_rv;

  logic        w_rst;
  logic        w_accept;
  logic        w_wr;
  logic        w_rd;
  logic        w_blocked;
  logic        w_wr_sbcs;
  logic        w_wr_addr0;
  logic        w_wr_addr1;
  logic        w_wr_data0;
  logic        w_wr_data1;
  logic        w_rd_data0;
  logic        w_busy_hit;
  logic        w_addr_wv_nxt;
  logic        w_data_wv_nxt;
  logic        w_data_rv_nxt;
  logic        w_issue_read;
  logic [31:0] w_rdata;
  sbcs_t       w_sbcs_rd;
  sbcs_t       w_sbcs_wr;
  logic        w_unused;

  assign w_rst     = rst_i || !dmactive_i;
  assign w_accept  = dmi_req_valid_i && !r_resp_valid;
  assign w_wr      = w_accept && (dmi_op_i == DMI_WRITE);
  assign w_rd      = w_accept && (dmi_op_i == DMI_READ);
  assign w_blocked = r_sbbusyerror || (r_sberror != 3'd0);

  assign w_wr_sbcs  = w_wr && (dmi_addr_i == ADDR_SBCS);
  assign w_wr_addr0 = w_wr && (dmi_addr_i == ADDR_SBADDRESS0);
  assign w_wr_addr1 = w_wr && (dmi_addr_i == ADDR_SBADDRESS1);
  assign w_wr_data0 = w_wr && (dmi_addr_i == ADDR_SBDATA0);
  assign w_wr_data1 = w_wr && (dmi_addr_i == ADDR_SBDATA1);
  assign w_rd_data0 = w_rd && (dmi_addr_i == ADDR_SBDATA0);

  // Touching sbaddress0/sbdata0 while the master is busy is a sticky error.
  assign w_busy_hit    = sbbusy_i && (w_wr_addr0 || w_wr_data0 || w_rd_data0);
  assign w_addr_wv_nxt = w_wr_addr0 && !sbbusy_i && !w_blocked;
  assign w_data_wv_nxt = w_wr_data0 && !sbbusy_i && !w_blocked;
  assign w_data_rv_nxt = w_rd_data0 && !sbbusy_i && !w_blocked;
  assign w_issue_read  = (w_addr_wv_nxt && r_sbreadonaddr) ||
                         (w_data_rv_nxt && r_sbreadondata);

  assign w_sbcs_wr = sbcs_t'(dmi_data_i);

  always_comb begin
    w_sbcs_rd                 = '0;
    w_sbcs_rd.sbversion       = 3'd1;
    w_sbcs_rd.sbbusyerror     = r_sbbusyerror;
    w_sbcs_rd.sbbusy          = sbbusy_i;
    w_sbcs_rd.sbreadonaddr    = r_sbreadonaddr;
    w_sbcs_rd.sbaccess        = r_sbaccess;
    w_sbcs_rd.sbautoincrement = r_sbautoincrement;
    w_sbcs_rd.sbreadondata    = r_sbreadondata;
    w_sbcs_rd.sberror         = r_sberror;
    w_sbcs_rd.sbasize         = 7'(SBASIZE);
    w_sbcs_rd.sbaccess_caps   = 5'b01111;
  end

  always_comb begin
    w_rdata = '0;
    case (dmi_addr_i)
      ADDR_SBCS:       w_rdata = w_sbcs_rd;
      ADDR_SBADDRESS0: w_rdata = r_sbaddress[31:0];
      ADDR_SBADDRESS1: w_rdata = r_sbaddress[63:32];
      ADDR_SBDATA0:    w_rdata = r_sbdata[31:0];
      ADDR_SBDATA1:    w_rdata = r_sbdata[63:32];
      default:         w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (w_rst) begin
      r_sbaddress       <= '0;
      r_sbdata          <= '0;
      r_sbbusyerror     <= 1'b0;
      r_sbreadonaddr    <= 1'b0;
      r_sbaccess        <= 3'd2;
      r_sbautoincrement <= 1'b0;
      r_sbreadondata    <= 1'b0;
      r_sberror         <= '0;
      r_read_pending    <= 1'b0;
      r_resp_valid      <= 1'b0;
      r_resp_data       <= '0;
      r_addr_wv         <= 1'b0;
      r_data_wv         <= 1'b0;
      r_data_rv         <= 1'b0;
    end else begin
      if (w_accept) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= w_rd ? w_rdata : 32'd0;
      end else if (dmi_resp_ready_i) begin
        r_resp_valid <= 1'b0;
      end

      r_addr_wv <= w_addr_wv_nxt;
      r_data_wv <= w_data_wv_nxt;
      r_data_rv <= w_data_rv_nxt;

      if (w_wr_sbcs) begin
        r_sbreadonaddr    <= w_sbcs_wr.sbreadonaddr;
        r_sbaccess        <= w_sbcs_wr.sbaccess;
        r_sbautoincrement <= w_sbcs_wr.sbautoincrement;
        r_sbreadondata    <= w_sbcs_wr.sbreadondata;
      end

      if (w_busy_hit)
        r_sbbusyerror <= 1'b1;
      else if (w_wr_sbcs && w_sbcs_wr.sbbusyerror)
        r_sbbusyerror <= 1'b0;

      // A master-reported error wins over a same-cycle W1C clear.
      if (sberror_valid_i)
        r_sberror <= sberror_i;
      else if (w_wr_sbcs)
        r_sberror <= r_sberror & ~w_sbcs_wr.sberror;

      if (sbdata_valid_i)
        r_sbaddress <= sbaddress_next_i;
      if (w_wr_addr0 && !sbbusy_i)
        r_sbaddress[31:0] <= dmi_data_i;
      if (w_wr_addr1)
        r_sbaddress[63:32] <= dmi_data_i;

      if (sbdata_valid_i && r_read_pending)
        r_sbdata <= sbdata_i;
      if (w_wr_data0 && !sbbusy_i)
        r_sbdata[31:0] <= dmi_data_i;
      if (w_wr_data1)
        r_sbdata[63:32] <= dmi_data_i;

      if (w_issue_read)
        r_read_pending <= 1'b1;
      else if (sbdata_valid_i)
        r_read_pending <= 1'b0;
    end
  end

  assign dmi_req_ready_o         = !r_resp_valid;
  assign dmi_resp_valid_o        = r_resp_valid;
  assign dmi_resp_data_o         = r_resp_data;
  assign sbaddress_o             = r_sbaddress;
  assign sbdata_o                = r_sbdata;
  assign sbaddress_write_valid_o = r_addr_wv;
  assign sbdata_write_valid_o    = r_data_wv;
  assign sbdata_read_valid_o     = r_data_rv;
  assign sbreadonaddr_o          = r_sbreadonaddr;
  assign sbautoincrement_o       = r_sbautoincrement;
  assign sbaccess_o              = r_sbaccess;
  assign sbreadondata_o          = r_sbreadondata;

  assign w_unused = ^{w_sbcs_wr.sbversion, w_sbcs_wr.zero0, w_sbcs_wr.sbbusy,
                      w_sbcs_wr.sbasize, w_sbcs_wr.sbaccess_caps};

endmodule

// File: tb/tb_sba_csr.sv
// Bench for sba_csr: table of DMI transactions plus hand-written sequences for
// bus responses, busy/error blocking, response backpressure and dmactive clear.
module tb_sba_csr;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        dmactive_i;
  logic        dmi_req_valid_i;
  logic        dmi_req_ready_o;
  logic [6:0]  dmi_addr_i;
  logic [1:0]  dmi_op_i;
  logic [31:0] dmi_data_i;
  logic        dmi_resp_valid_o;
  logic        dmi_resp_ready_i;
  logic [31:0] dmi_resp_data_o;
  logic [63:0] sbaddress_o;
  logic        sbaddress_write_valid_o;
  logic        sbreadonaddr_o;
  logic        sbautoincrement_o;
  logic [2:0]  sbaccess_o;
  logic        sbreadondata_o;
  logic [63:0] sbdata_o;
  logic        sbdata_read_valid_o;
  logic        sbdata_write_valid_o;
  logic [63:0] sbaddress_next_i;
  logic [63:0] sbdata_i;
  logic        sbdata_valid_i;
  logic        sbbusy_i;
  logic        sberror_valid_i;
  logic [2:0]  sberror_i;

  always #5 clk_i = ~clk_i;

  sba_csr #(.SBASIZE(64)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .dmactive_i(dmactive_i),
    .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
    .dmi_addr_i(dmi_addr_i), .dmi_op_i(dmi_op_i), .dmi_data_i(dmi_data_i),
    .dmi_resp_valid_o(dmi_resp_valid_o), .dmi_resp_ready_i(dmi_resp_ready_i),
    .dmi_resp_data_o(dmi_resp_data_o),
    .sbaddress_o(sbaddress_o), .sbaddress_write_valid_o(sbaddress_write_valid_o),
    .sbreadonaddr_o(sbreadonaddr_o), .sbautoincrement_o(sbautoincrement_o),
    .sbaccess_o(sbaccess_o), .sbreadondata_o(sbreadondata_o),
    .sbdata_o(sbdata_o), .sbdata_read_valid_o(sbdata_read_valid_o),
    .sbdata_write_valid_o(sbdata_write_valid_o),
    .sbaddress_next_i(sbaddress_next_i), .sbdata_i(sbdata_i),
    .sbdata_valid_i(sbdata_valid_i), .sbbusy_i(sbbusy_i),
    .sberror_valid_i(sberror_valid_i), .sberror_i(sberror_i)
  );

  localparam logic [1:0] OP_RD = 2'd1;
  localparam logic [1:0] OP_WR = 2'd2;

  typedef struct {
    logic [6:0]  addr;
    logic [1:0]  op;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  strb;    // {addr_write_valid, data_write_valid, data_read_valid}
    logic [63:0] sbaddr;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response scoreboard: every handshake pops the value queued at request time.
  always @(negedge clk_i) begin
    if (dmi_resp_valid_o && dmi_resp_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: got %h with nothing queued", dmi_resp_data_o);
      end else begin
        chk("resp_data", {32'd0, dmi_resp_data_o}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic dmi_xfer(input logic [6:0] a, input logic [1:0] op, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic [2:0] exp_strb,
                          input string name);
    @(negedge clk_i);
    for (int k = 0; k < 20 && !dmi_req_ready_o; k++) @(negedge clk_i);
    if (!dmi_req_ready_o) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s_ready: got 0 expected 1 within 20 cycles", name);
      return;
    end
    dmi_req_valid_i = 1'b1;
    dmi_addr_i      = a;
    dmi_op_i        = op;
    dmi_data_i      = wd;
    exp_q.push_back((op == OP_RD) ? exp_rd : 32'd0);
    @(posedge clk_i);
    #1;
    dmi_req_valid_i = 1'b0;
    dmi_op_i        = 2'd0;
    chk({name, "_rvalid"}, {63'd0, dmi_resp_valid_o}, 64'd1);
    chk({name, "_strb"}, {61'd0, sbaddress_write_valid_o, sbdata_write_valid_o,
                          sbdata_read_valid_o}, {61'd0, exp_strb});
    @(posedge clk_i);
    #1;
    chk({name, "_pulse"}, {61'd0, sbaddress_write_valid_o, sbdata_write_valid_o,
                           sbdata_read_valid_o}, 64'd0);
  endtask

  task automatic bus_resp(input logic [63:0] data, input logic [63:0] next_addr);
    @(negedge clk_i);
    sbdata_valid_i   = 1'b1;
    sbdata_i         = data;
    sbaddress_next_i = next_addr;
    @(negedge clk_i);
    sbdata_valid_i   = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; dmactive_i = 1'b1;
    dmi_req_valid_i = 1'b0; dmi_addr_i = '0; dmi_op_i = '0; dmi_data_i = '0;
    dmi_resp_ready_i = 1'b1;
    sbaddress_next_i = '0; sbdata_i = '0; sbdata_valid_i = 1'b0;
    sbbusy_i = 1'b0; sberror_valid_i = 1'b0; sberror_i = '0;

    vecs[0] = '{7'h38, OP_RD, 32'h0,          32'h2004_080F, 3'b000, 64'h0};
    vecs[1] = '{7'h38, OP_WR, 32'h0014_0000,  32'h0,         3'b000, 64'h0};
    vecs[2] = '{7'h38, OP_RD, 32'h0,          32'h2014_080F, 3'b000, 64'h0};
    vecs[3] = '{7'h3A, OP_WR, 32'h0,          32'h0,         3'b000, 64'h0};
    vecs[4] = '{7'h39, OP_WR, 32'h0000_1000,  32'h0,         3'b100, 64'h1000};
    vecs[5] = '{7'h39, OP_RD, 32'h0,          32'h0000_1000, 3'b000, 64'h1000};
    vecs[6] = '{7'h10, OP_RD, 32'h0,          32'h0,         3'b000, 64'h1000};
    vecs[7] = '{7'h10, OP_WR, 32'h0000_FFFF,  32'h0,         3'b000, 64'h1000};
    vecs[8] = '{7'h38, OP_RD, 32'h0,          32'h2014_080F, 3'b000, 64'h1000};

    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    chk("rst_req_ready", {63'd0, dmi_req_ready_o}, 64'd1);
    chk("rst_resp_valid", {63'd0, dmi_resp_valid_o}, 64'd0);
    chk("rst_sbaccess", {61'd0, sbaccess_o}, 64'd2);
    chk("rst_sbaddress", sbaddress_o, 64'd0);

    for (int i = 0; i < 9; i++) begin
      dmi_xfer(vecs[i].addr, vecs[i].op, vecs[i].wdata, vecs[i].rdata, vecs[i].strb,
               $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_sbaddr", i), sbaddress_o, vecs[i].sbaddr);
    end
    chk("cfg_sbaccess", {61'd0, sbaccess_o}, 64'd2);
    chk("cfg_readonaddr", {63'd0, sbreadonaddr_o}, 64'd1);

    // Read on address is pending: bus data and next address are captured.
    bus_resp(64'hDEADBEEF_CAFEF00D, 64'h1004);
    chk("cap_sbdata", sbdata_o, 64'hDEADBEEF_CAFEF00D);
    dmi_xfer(7'h3D, OP_RD, 0, 32'hDEADBEEF, 3'b000, "rd_sbdata1");
    dmi_xfer(7'h3C, OP_RD, 0, 32'hCAFEF00D, 3'b001, "rd_sbdata0");
    dmi_xfer(7'h39, OP_RD, 0, 32'h0000_1004, 3'b000, "rd_sbaddr0");
    dmi_xfer(7'h3A, OP_RD, 0, 32'h0, 3'b000, "rd_sbaddr1");

    // Busy access sets sbbusyerror and blocks strobes until cleared.
    @(negedge clk_i); sbbusy_i = 1'b1;
    dmi_xfer(7'h3C, OP_WR, 32'h55, 0, 3'b000, "busy_wr");
    dmi_xfer(7'h38, OP_RD, 0, 32'h2074_080F, 3'b000, "busy_sbcs");
    @(negedge clk_i); sbbusy_i = 1'b0;
    dmi_xfer(7'h3C, OP_WR, 32'h66, 0, 3'b000, "blocked_wr");
    dmi_xfer(7'h3C, OP_RD, 0, 32'h66, 3'b000, "blocked_rd");
    dmi_xfer(7'h38, OP_WR, 32'h0054_0000, 0, 3'b000, "clr_busyerr");
    dmi_xfer(7'h38, OP_RD, 0, 32'h2014_080F, 3'b000, "busy_cleared");
    dmi_xfer(7'h3C, OP_WR, 32'h77, 0, 3'b010, "unblocked_wr");
    dmi_xfer(7'h3D, OP_WR, 32'hA5A5_A5A5, 0, 3'b000, "wr_sbdata1");
    chk("sbdata_hi_lo", sbdata_o, 64'hA5A5A5A5_00000077);

    // Bus error blocks reads; W1C of all error bits unblocks.
    @(negedge clk_i); sberror_valid_i = 1'b1; sberror_i = 3'd3;
    @(negedge clk_i); sberror_valid_i = 1'b0; sberror_i = 3'd0;
    dmi_xfer(7'h38, OP_RD, 0, 32'h2014_380F, 3'b000, "err_sbcs");
    dmi_xfer(7'h3C, OP_RD, 0, 32'h77, 3'b000, "err_rd");
    dmi_xfer(7'h38, OP_WR, 32'h0014_7000, 0, 3'b000, "err_clr");
    dmi_xfer(7'h38, OP_RD, 0, 32'h2014_080F, 3'b000, "err_cleared");
    dmi_xfer(7'h3C, OP_RD, 0, 32'h77, 3'b001, "err_rd_ok");

    // No read pending: address follows the master, data is left alone.
    bus_resp(64'h1111_2222_3333_4444, 64'h2000);
    chk("nopend_sbdata", sbdata_o, 64'hA5A5A5A5_00000077);
    chk("nopend_sbaddr", sbaddress_o, 64'h2000);

    // Backpressure: response held stable, no new request accepted.
    @(posedge clk_i); #1; dmi_resp_ready_i = 1'b0;
    @(negedge clk_i);
    dmi_req_valid_i = 1'b1; dmi_addr_i = 7'h39; dmi_op_i = OP_RD;
    exp_q.push_back(32'h2000);
    @(posedge clk_i); #1;
    dmi_req_valid_i = 1'b0; dmi_op_i = 2'd0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d_valid", c), {63'd0, dmi_resp_valid_o}, 64'd1);
      chk($sformatf("stall%0d_data", c), {32'd0, dmi_resp_data_o}, 64'h2000);
      chk($sformatf("stall%0d_ready", c), {63'd0, dmi_req_ready_o}, 64'd0);
      @(posedge clk_i); #1;
    end
    dmi_resp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk("stall_done", {63'd0, dmi_resp_valid_o}, 64'd0);

    // dmactive low drops a pending response and clears all state.
    dmi_resp_ready_i = 1'b0;
    @(negedge clk_i);
    dmi_req_valid_i = 1'b1; dmi_addr_i = 7'h38; dmi_op_i = OP_RD;
    @(posedge clk_i); #1;
    dmi_req_valid_i = 1'b0; dmi_op_i = 2'd0;
    chk("dma_pending", {63'd0, dmi_resp_valid_o}, 64'd1);
    @(negedge clk_i); dmactive_i = 1'b0;
    @(posedge clk_i); #1;
    chk("dma_resp_valid", {63'd0, dmi_resp_valid_o}, 64'd0);
    chk("dma_req_ready", {63'd0, dmi_req_ready_o}, 64'd1);
    chk("dma_sbaccess", {61'd0, sbaccess_o}, 64'd2);
    chk("dma_sbaddress", sbaddress_o, 64'd0);
    chk("dma_sbdata", sbdata_o, 64'd0);
    chk("dma_readonaddr", {63'd0, sbreadonaddr_o}, 64'd0);
    dmactive_i = 1'b1;
    dmi_resp_ready_i = 1'b1;
    dmi_xfer(7'h38, OP_RD, 0, 32'h2004_080F, 3'b000, "dma_sbcs");
    dmi_xfer(7'h39, OP_RD, 0, 32'h0, 3'b000, "dma_addr0");
    dmi_xfer(7'h3A, OP_RD, 0, 32'h0, 3'b000, "dma_addr1");
    dmi_xfer(7'h3C, OP_RD, 0, 32'h0, 3'b001, "dma_data0");
    dmi_xfer(7'h3D, OP_RD, 0, 32'h0, 3'b000, "dma_data1");

    repeat (2) @(posedge clk_i);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/sba_csr.md
SBA_CSR -- requirements
Module: sba_csr

Interface
REQ-001 SHALL have parameter SBASIZE, default 64, meaning bus address width reported in sbcs.sbasize.
REQ-002 SHALL have port clk_i, input, 1, the only clock; all state SHALL be updated on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset; reset is synchronous and active-high.
REQ-004 SHALL have port dmactive_i, input, 1, debug module active; low acts as a synchronous clear.
REQ-005 SHALL have DMI request ports: dmi_req_valid_i in 1; dmi_req_ready_o out 1; dmi_addr_i in 7; dmi_op_i in 2 (0 nop, 1 read, 2 write); dmi_data_i in 32.
REQ-006 SHALL have DMI response ports: dmi_resp_valid_o out 1; dmi_resp_ready_i in 1; dmi_resp_data_o out 32.
REQ-007 SHALL have ports to the SBA master: sbaddress_o out 64; sbaddress_write_valid_o out 1; sbreadonaddr_o out 1; sbautoincrement_o out 1; sbaccess_o out 3; sbreadondata_o out 1; sbdata_o out 64; sbdata_read_valid_o out 1; sbdata_write_valid_o out 1.
REQ-008 SHALL have ports from the SBA master: sbaddress_next_i in 64 (post-increment address); sbdata_i in 64; sbdata_valid_i in 1; sbbusy_i in 1; sberror_valid_i in 1; sberror_i in 3.

Function
REQ-009 SHALL decode addresses 0x38 sbcs, 0x39 sbaddress0, 0x3A sbaddress1, 0x3C sbdata0, 0x3D sbdata1; other addresses SHALL read 0 and ignore writes.
REQ-010 SHALL accept a request when dmi_req_valid_i and dmi_req_ready_o; dmi_req_ready_o = !dmi_resp_valid_o (one outstanding).
REQ-011 SHALL assert dmi_resp_valid_o the cycle after acceptance and hold it and dmi_resp_data_o stable until dmi_resp_ready_i; writes and nops SHALL respond with data 0.
REQ-012 sbcs read SHALL be {3'd1, 6'b0, sbbusyerror, sbbusy_i, sbreadonaddr, sbaccess, sbautoincrement, sbreadondata, sberror, SBASIZE[6:0], 5'b01111}.
REQ-013 sbcs write SHALL update sbreadonaddr, sbaccess, sbautoincrement, sbreadondata at any time, and clear sbbusyerror/sberror bits written as 1 (W1C).
REQ-014 "Blocked" SHALL mean sbbusyerror!=0 or sberror!=0.
REQ-015 sbaddress0 write while sbbusy_i=1 SHALL set sbbusyerror and not modify the address.
REQ-016 sbaddress0 write otherwise SHALL update sbaddress[31:0]; if not blocked, sbaddress_write_valid_o SHALL pulse for exactly one cycle, the cycle after acceptance.
REQ-017 sbaddress1 and sbdata1 writes SHALL update bits [63:32] and SHALL NOT pulse any strobe.
REQ-018 sbdata0 write while sbbusy_i=1 SHALL set sbbusyerror; otherwise SHALL update sbdata[31:0] and, if not blocked, pulse sbdata_write_valid_o one cycle.
REQ-019 sbdata0 read SHALL return the current sbdata[31:0]; if sbbusy_i=1 it SHALL set sbbusyerror; otherwise, if not blocked, it SHALL pulse sbdata_read_valid_o one cycle.
REQ-020 SHALL set flag read_pending when issuing a read (sbaddress_write_valid_o with sbreadonaddr=1, or sbdata_read_valid_o with sbreadondata=1), and SHALL clear it on sbdata_valid_i.
REQ-021 On sbdata_valid_i SHALL capture sbaddress_next_i into sbaddress; sbdata_i SHALL be captured into sbdata only if read_pending.
REQ-022 On sberror_valid_i SHALL load sberror from sberror_i; a W1C write in the same cycle SHALL lose.
REQ-023 sbaddress_o and sbdata_o SHALL be the register contents; configuration outputs SHALL mirror the sbcs fields.

Reset
REQ-024 On rst_i or !dmactive_i all registers, read_pending, strobes and dmi_resp_valid_o SHALL be 0, and sbaccess SHALL be 3'd2; dmi_req_ready_o SHALL be 1.
REQ-025 Reset mid-transaction SHALL discard any pending response without a handshake.

Structure
REQ-026 DMI op enum, the five register address constants and an sbcs packed struct SHALL live in the shared debug package dm_pkg.
REQ-027 SHALL be a single module without sub-modules; the SBA master SHALL be instantiated by the parent.

Verification
REQ-028 Write sbcs=0x0010_0000|(2<<17), then sbaddress0=0x1000 -> sbaddress_write_valid_o is 1 for one cycle, sbaddress_o=0x1000.
REQ-029 Read issued, then sbdata_valid_i with sbdata_i=0xDEADBEEF_CAFEF00D and sbaddress_next_i=0x1004 -> sbdata1 reads 0xDEADBEEF, sbdata0 reads 0xCAFEF00D, sbaddress0 reads 0x1004.
REQ-030 sbdata0 write 0x55 with sbbusy_i=1 -> no strobe, sbcs[22]=1; a later write with sbbusy_i=0 gives no strobe until sbcs is written with bit22=1.
REQ-031 sberror_valid_i with sberror_i=3 -> sbcs[14:12]=3; sbdata0 read produces no strobe; writing sbcs with [14:12]=7 clears it.
REQ-032 Keep dmi_resp_ready_i=0 for 5 cycles -> response data stable and dmi_req_ready_o=0 throughout; dmactive_i=0 -> all registers read 0 and sbaccess reads 2.
